ifetch_unit: RTL and testbench

Instruction fetch stage sitting directly upstream of `controller`: owns the fetch PC, issues word requests to instruction memory over a req/ready handshake, and holds the fetched word in a single-entry instruction register whose `op`/`funct` fields drive the controller. It accepts downstream stall and branch/jump redirects, discards in-flight wrong-path fetches, and never drops a memory request once issued.

---
 rtl/ifetch_unit.sv | 122 ++++++++++++
 tb/tb_ifetch_unit.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns the fetch PC, runs the req/ready handshake to
// instruction memory, and holds one fetched word for the controller.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instr,
  output logic [5:0]  op,
  output logic [5:0]  funct,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pcplus4
);

  typedef enum logic {ST_FETCH, ST_DRAIN} state_t;

  state_t      r_state, w_state_next;
  logic [31:0] r_fetch_pc, w_fetch_pc_next;
  logic        r_pending, w_pending_next;
  logic [31:0] r_target, w_target_next;
  logic [31:0] r_instr, w_instr_next;
  logic [31:0] r_pc, w_pc_next;
  logic        r_instr_valid, w_instr_valid_next;
  logic        w_req;
  logic        w_consume;
  logic [31:0] w_redirect_aligned;

  assign w_redirect_aligned = redirect_pc & ~32'h3;
  assign w_consume          = r_instr_valid && !stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_FETCH;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next       = r_state;
    w_fetch_pc_next    = r_fetch_pc;
    w_pending_next     = r_pending;
    w_target_next      = r_target;
    w_instr_next       = r_instr;
    w_pc_next          = r_pc;
    w_instr_valid_next = r_instr_valid;
    w_req              = 1'b0;
    case (r_state)
      ST_FETCH: begin
        // An issued request is never withdrawn, even across a redirect.
        w_req = r_pending || (!redirect && (!r_instr_valid || !stall));
        if (redirect) begin
          w_instr_valid_next = 1'b0;
          if (r_pending && !imem_ready) begin
            w_target_next = w_redirect_aligned;
            w_state_next  = ST_DRAIN;
          end else begin
            w_fetch_pc_next = w_redirect_aligned;
            w_pending_next  = 1'b0;
          end
        end else if (w_req && imem_ready) begin
          w_instr_next       = imem_rdata;
          w_pc_next          = r_fetch_pc;
          w_instr_valid_next = 1'b1;
          w_fetch_pc_next    = r_fetch_pc + 32'd4;
          w_pending_next     = 1'b0;
        end else begin
          if (w_consume) w_instr_valid_next = 1'b0;
          if (w_req)     w_pending_next     = 1'b1;
        end
      end
      ST_DRAIN: begin
        // Finish the wrong-path request, then jump to the latest target.
        w_req              = 1'b1;
        w_instr_valid_next = 1'b0;
        if (redirect) w_target_next = w_redirect_aligned;
        if (imem_ready) begin
          w_fetch_pc_next = redirect ? w_redirect_aligned : r_target;
          w_pending_next  = 1'b0;
          w_state_next    = ST_FETCH;
        end
      end
      default: w_state_next = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_pc    <= RESET_PC;
      r_pending     <= 1'b0;
      r_target      <= RESET_PC;
      r_instr       <= 32'h0;
      r_pc          <= RESET_PC;
      r_instr_valid <= 1'b0;
    end else begin
      r_fetch_pc    <= w_fetch_pc_next;
      r_pending     <= w_pending_next;
      r_target      <= w_target_next;
      r_instr       <= w_instr_next;
      r_pc          <= w_pc_next;
      r_instr_valid <= w_instr_valid_next;
    end
  end

  assign imem_req    = w_req && !reset;
  assign imem_addr   = r_fetch_pc;
  assign instr       = r_instr;
  assign op          = r_instr[31:26];
  assign funct       = r_instr[5:0];
  assign instr_valid = r_instr_valid;
  assign pc          = r_pc;
  assign pcplus4     = r_pc + 32'd4;

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed cycle-by-cycle bench for ifetch_unit; inputs change on the falling
// edge and outputs are checked 1ns later, ahead of the next rising edge.
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        reset, imem_ready, stall, redirect;
  logic [31:0] imem_rdata, redirect_pc;
  logic        imem_req, instr_valid;
  logic [31:0] imem_addr, instr, pc, pcplus4;
  logic [5:0]  op, funct;
  int n_cmp = 0;
  int n_err = 0;

  localparam logic [31:0] R0 = 32'h0232_8020;
  localparam logic [31:0] R1 = 32'h8C43_0004;
  localparam logic [31:0] R2 = 32'h2002_0005;
  localparam logic [31:0] R3 = 32'hAAAA_AA3F;
  localparam logic [31:0] R4 = 32'h1111_1100;
  localparam logic [31:0] R5 = 32'h2222_2201;
  localparam logic [31:0] R6 = 32'h3333_3302;
  localparam logic [31:0] R7 = 32'h4444_4407;

  ifetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc), .instr(instr), .op(op),
    .funct(funct), .instr_valid(instr_valid), .pc(pc), .pcplus4(pcplus4)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic rst, input logic rdy, input logic [31:0] rd,
                       input logic stl, input logic rdr, input logic [31:0] rpc);
    @(negedge clk);
    reset = rst; imem_ready = rdy; imem_rdata = rd;
    stall = stl; redirect = rdr; redirect_pc = rpc;
    #1;
    $display("t=%0t rst=%b rdy=%b stall=%b redir=%b | req=%b addr=%h valid=%b pc=%h instr=%h",
             $time, rst, rdy, stl, rdr, imem_req, imem_addr, instr_valid, pc, instr);
  endtask

  task automatic test_reset;
    drive(1, 0, 32'h0, 0, 0, 32'h0);
    drive(1, 0, 32'h0, 0, 0, 32'h0);
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rst_req got=%b want=0", imem_req); end
    n_cmp++; if (instr !== 32'h0) begin n_err++; $display("FAIL rst_instr got=%h want=0", instr); end
    n_cmp++; if (op !== 6'h0 || funct !== 6'h0) begin n_err++; $display("FAIL rst_opfunct got=%h/%h want=0/0", op, funct); end
    n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got=%b want=0", instr_valid); end
    n_cmp++; if (pc !== 32'h0) begin n_err++; $display("FAIL rst_pc got=%h want=0", pc); end
    n_cmp++; if (pcplus4 !== 32'h4) begin n_err++; $display("FAIL rst_pcplus4 got=%h want=4", pcplus4); end
  endtask

  task automatic test_stream;
    drive(0, 1, R0, 0, 0, 32'h0);
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_err++; $display("FAIL s1_req got=%b/%h want=1/0", imem_req, imem_addr); end
    n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL s1_valid got=%b want=0", instr_valid); end
    drive(0, 1, R1, 0, 0, 32'h0);
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin n_err++; $display("FAIL s2_req got=%b/%h want=1/4", imem_req, imem_addr); end
    n_cmp++; if (instr_valid !== 1'b1 || instr !== R0) begin n_err++; $display("FAIL s2_instr got=%b/%h want=1/%h", instr_valid, instr, R0); end
    n_cmp++; if (op !== 6'h00 || funct !== 6'h20) begin n_err++; $display("FAIL s2_opfunct got=%h/%h want=00/20", op, funct); end
    n_cmp++; if (pc !== 32'h0 || pcplus4 !== 32'h4) begin n_err++; $display("FAIL s2_pc got=%h/%h want=0/4", pc, pcplus4); end
    drive(0, 1, R2, 0, 0, 32'h0);
    n_cmp++; if (imem_addr !== 32'h8) begin n_err++; $display("FAIL s3_addr got=%h want=8", imem_addr); end
    n_cmp++; if (instr !== R1 || pc !== 32'h4 || pcplus4 !== 32'h8) begin n_err++; $display("FAIL s3_instr got=%h pc=%h/%h want=%h pc=4/8", instr, pc, pcplus4, R1); end
    n_cmp++; if (op !== 6'h23 || funct !== 6'h04) begin n_err++; $display("FAIL s3_opfunct got=%h/%h want=23/04", op, funct); end
  endtask

  task automatic test_wait_states;
    drive(0, 0, 32'h0, 0, 0, 32'h0);
    n_cmp++; if (instr_valid !== 1'b1 || instr !== R2 || pc !== 32'h8) begin n_err++; $display("FAIL w0_instr got=%b/%h/%h want=1/%h/8", instr_valid, instr, pc, R2); end
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'hC) begin n_err++; $display("FAIL w0_req got=%b/%h want=1/c", imem_req, imem_addr); end
    for (int i = 1; i < 4; i++) begin
      if (i == 3) drive(0, 1, R3, 0, 0, 32'h0);
      else        drive(0, 0, 32'h0, 0, 0, 32'h0);
      n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'hC) begin n_err++; $display("FAIL w%0d_req got=%b/%h want=1/c", i, imem_req, imem_addr); end
      n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL w%0d_valid got=%b want=0", i, instr_valid); end
    end
  endtask

  task automatic test_stall;
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 32'hDEAD_BEEF, 1, 0, 32'h0);
      n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL st%0d_req got=%b want=0", i, imem_req); end
      n_cmp++; if (instr_valid !== 1'b1 || instr !== R3 || pc !== 32'hC) begin n_err++; $display("FAIL st%0d_hold got=%b/%h/%h want=1/%h/c", i, instr_valid, instr, pc, R3); end
    end
    drive(0, 1, R4, 0, 0, 32'h0);
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin n_err++; $display("FAIL st_resume got=%b/%h want=1/10", imem_req, imem_addr); end
  endtask

  task automatic test_redirect;
    drive(0, 1, 32'hDEAD_BEEF, 0, 1, 32'h43);
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rd0_req got=%b want=0", imem_req); end
    n_cmp++; if (instr !== R4 || pc !== 32'h10) begin n_err++; $display("FAIL rd0_instr got=%h/%h want=%h/10", instr, pc, R4); end
    drive(0, 1, R5, 0, 0, 32'h0);
    n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL rd1_valid got=%b want=0", instr_valid); end
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin n_err++; $display("FAIL rd1_req got=%b/%h want=1/40", imem_req, imem_addr); end
    drive(0, 0, 32'h0, 1, 0, 32'h0);
    n_cmp++; if (instr_valid !== 1'b1 || instr !== R5 || pc !== 32'h40) begin n_err++; $display("FAIL rd2_instr got=%b/%h/%h want=1/%h/40", instr_valid, instr, pc, R5); end
    n_cmp++; if (pcplus4 !== 32'h44 || imem_req !== 1'b0) begin n_err++; $display("FAIL rd2_misc got=%h/%b want=44/0", pcplus4, imem_req); end
  endtask

  task automatic test_drain;
    drive(0, 0, 32'h0, 0, 1, 32'h10);
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL dr0_req got=%b want=0", imem_req); end
    drive(0, 0, 32'h0, 0, 0, 32'h0);
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin n_err++; $display("FAIL dr1_req got=%b/%h want=1/10", imem_req, imem_addr); end
    drive(0, 0, 32'h0, 0, 1, 32'h80);
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin n_err++; $display("FAIL dr2_req got=%b/%h want=1/10", imem_req, imem_addr); end
    drive(0, 0, 32'h0, 0, 1, 32'h93);
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h10 || instr_valid !== 1'b0) begin n_err++; $display("FAIL dr3 got=%b/%h/%b want=1/10/0", imem_req, imem_addr, instr_valid); end
    drive(0, 1, 32'hBAD0_BAD0, 0, 0, 32'h0);
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h10 || instr_valid !== 1'b0) begin n_err++; $display("FAIL dr4 got=%b/%h/%b want=1/10/0", imem_req, imem_addr, instr_valid); end
    drive(0, 1, R6, 0, 0, 32'h0);
    n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL dr5_valid got=%b want=0", instr_valid); end
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h90) begin n_err++; $display("FAIL dr5_req got=%b/%h want=1/90", imem_req, imem_addr); end
    drive(0, 0, 32'h0, 0, 0, 32'h0);
    n_cmp++; if (instr_valid !== 1'b1 || instr !== R6 || pc !== 32'h90 || funct !== 6'h02) begin n_err++; $display("FAIL dr6_instr got=%b/%h/%h want=1/%h/90", instr_valid, instr, pc, R6); end
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h94) begin n_err++; $display("FAIL dr6_req got=%b/%h want=1/94", imem_req, imem_addr); end
  endtask

  task automatic test_reset_in_drain;
    drive(0, 0, 32'h0, 0, 1, 32'h200);
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h94) begin n_err++; $display("FAIL rsd0_req got=%b/%h want=1/94", imem_req, imem_addr); end
    drive(1, 0, 32'h0, 0, 0, 32'h0);
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rsd1_req got=%b want=0", imem_req); end
    drive(0, 1, R0, 0, 0, 32'h0);
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_err++; $display("FAIL rsd2_req got=%b/%h want=1/0", imem_req, imem_addr); end
    n_cmp++; if (instr_valid !== 1'b0 || instr !== 32'h0 || pc !== 32'h0 || op !== 6'h0) begin n_err++; $display("FAIL rsd2_state got=%b/%h/%h want=0/0/0", instr_valid, instr, pc); end
  endtask

  task automatic test_wrap;
    drive(0, 0, 32'h0, 0, 1, 32'hFFFF_FFFF);
    n_cmp++; if (instr_valid !== 1'b1 || instr !== R0 || pc !== 32'h0 || imem_req !== 1'b0) begin n_err++; $display("FAIL wr0 got=%b/%h/%h/%b want=1/%h/0/0", instr_valid, instr, pc, imem_req, R0); end
    drive(0, 1, R7, 0, 0, 32'h0);
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC || instr_valid !== 1'b0) begin n_err++; $display("FAIL wr1 got=%b/%h/%b want=1/fffffffc/0", imem_req, imem_addr, instr_valid); end
    drive(0, 0, 32'h0, 1, 0, 32'h0);
    n_cmp++; if (instr !== R7 || pc !== 32'hFFFF_FFFC || pcplus4 !== 32'h0) begin n_err++; $display("FAIL wr2_pc got=%h/%h/%h want=%h/fffffffc/0", instr, pc, pcplus4, R7); end
    n_cmp++; if (imem_req !== 1'b0 || imem_addr !== 32'h0) begin n_err++; $display("FAIL wr2_req got=%b/%h want=0/0", imem_req, imem_addr); end
  endtask

  initial begin
    reset = 1'b1; imem_ready = 1'b0; imem_rdata = 32'h0;
    stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    test_reset();
    test_stream();
    test_wait_states();
    test_stall();
    test_redirect();
    test_drain();
    test_reset_in_drain();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
